// File: rtl/event_packetizer_if.sv
// AXI-Stream link used on both sides of the event packetizer.
interface event_packetizer_if #(
  parameter int DW = 32
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/event_packetizer.sv
// Time-stamps detector pulse words on acceptance, buffers them in a FWFT FIFO
// and emits packets of events closed by a trailer word (full or idle timeout).
module event_packetizer #(
  parameter int FIFO_AW        = 4,
  parameter int PKT_LEN        = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  event_packetizer_if.slave  s_axis,
  event_packetizer_if.master m_axis,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [31:0]        packet_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FIFO_AW:0] DEPTH_V      = DEPTH[FIFO_AW:0];
  localparam logic [15:0]      PKT_LEN_V    = 16'(PKT_LEN);
  localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_TRAILER
  } state_t;

  state_t             state, state_nxt;
  logic [19:0]        ts;
  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               fifo_empty, fifo_full;
  logic               push, pop;
  logic [15:0]        evt_cnt, evt_cnt_inc;
  logic [TW-1:0]      idle_timer;
  logic [7:0]         seq;
  logic               pkt_full, timed_out;
  logic               unused_in;

  // Amplitude lives in [11:0]; the upper bits and the inbound tlast carry nothing here.
  assign unused_in = ^{s_axis.tdata[31:12], s_axis.tlast};

  assign fifo_empty    = (count == '0);
  assign fifo_full     = (count == DEPTH_V);
  assign fifo_level    = count;
  assign s_axis.tready = !fifo_full;
  assign push          = s_axis.tvalid && !fifo_full;
  assign pop           = (state == S_STREAM) && !fifo_empty && m_axis.tready;
  assign evt_cnt_inc   = evt_cnt + 16'd1;
  assign pkt_full      = pop && (evt_cnt_inc == PKT_LEN_V);
  assign timed_out     = fifo_empty && (idle_timer == TIMEOUT_LAST);

  // Free-running 20-bit timestamp.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) ts <= '0;
    else     ts <= ts + 20'd1;
  end

  // FIFO storage write: {timestamp, amplitude} captured on the accept cycle.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; the pointers and count decide which words are valid.
    if (push) mem[wr_ptr] <= {ts, s_axis.tdata[11:0]};
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the level.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state: open on data, close on full packet or idle timeout.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:    if (!fifo_empty) state_nxt = S_STREAM;
      S_STREAM:  if (pkt_full || timed_out) state_nxt = S_TRAILER;
      S_TRAILER: if (m_axis.tready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Per-packet event count, idle timer, trailer sequence and packet counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_cnt      <= '0;
      idle_timer   <= '0;
      seq          <= '0;
      packet_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          evt_cnt    <= '0;
          idle_timer <= '0;
        end
        S_STREAM: begin
          if (pop) begin
            evt_cnt    <= evt_cnt_inc;
            idle_timer <= '0;
          end else if (fifo_empty && !timed_out) begin
            // Words held by backpressure do not count as idle time.
            idle_timer <= idle_timer + TW'(1);
          end
        end
        S_TRAILER: begin
          if (m_axis.tready) begin
            seq          <= seq + 8'd1;
            packet_count <= packet_count + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM outputs: FIFO head while streaming, trailer word with tlast to close.
  always_comb begin
    m_axis.tvalid = 1'b0;
    m_axis.tlast  = 1'b0;
    m_axis.tdata  = '0;
    case (state)
      S_STREAM: begin
        m_axis.tvalid = !fifo_empty;
        m_axis.tdata  = fifo_empty ? 32'd0 : mem[rd_ptr];
      end
      S_TRAILER: begin
        m_axis.tvalid = 1'b1;
        m_axis.tlast  = 1'b1;
        m_axis.tdata  = {8'hA5, seq, evt_cnt};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_event_packetizer.sv
// Directed self-checking bench for event_packetizer (PKT_LEN=4, TIMEOUT_CYCLES=16).
module tb_event_packetizer;

  localparam int FIFO_AW        = 4;
  localparam int PKT_LEN        = 4;
  localparam int TIMEOUT_CYCLES = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [FIFO_AW:0] fifo_level;
  logic [31:0]      packet_count;

  event_packetizer_if s_if ();
  event_packetizer_if m_if ();

  event_packetizer #(
    .FIFO_AW       (FIFO_AW),
    .PKT_LEN       (PKT_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .fifo_level  (fifo_level),
    .packet_count(packet_count)
  );

  always #5 clk = ~clk;

  // Reference timestamp: zero at every reset edge, +1 per cycle otherwise.
  logic [19:0] tb_ts;
  always @(posedge clk) begin
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + 20'd1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, 32'(obs), 32'(exp));
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_if.tvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Present one event for one cycle; the expected output word is queued.
  task automatic push_event(input string tag, input logic [11:0] amp);
    s_if.tvalid = 1'b1;
    s_if.tdata  = {20'hABCDE, amp};
    @(negedge clk);
    check1({tag, "_sready"}, s_if.tready, 1'b1);
    exp_q.push_back({tb_ts, amp});
    tick();
    s_if.tvalid = 1'b0;
  endtask

  // Wait (bounded) for m_tvalid at a falling edge; a missed deadline is a failure.
  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (!m_if.tvalid && n < budget) begin
      tick();
      @(negedge clk);
      n++;
    end
    check1({tag, "_valid"}, m_if.tvalid, 1'b1);
  endtask

  // Expect one output beat, then let it transfer (m_tready must be high).
  task automatic expect_beat(input string tag, input logic [31:0] exp_data,
                             input logic exp_last, input int budget);
    wait_valid(tag, budget);
    check({tag, "_data"}, m_if.tdata, exp_data);
    check1({tag, "_last"}, m_if.tlast, exp_last);
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] prev_data;
    logic        prev_last;
    logic        prev_stall;
    logic        saw_valid;
    int          accepted;
    int          xfers;
    int          stalls;

    rst         = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;

    // 1: reset held three cycles.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check1("rst_tvalid", m_if.tvalid, 1'b0);
    check1("rst_tlast", m_if.tlast, 1'b0);
    check("rst_tdata", m_if.tdata, 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_pkt_count", packet_count, 32'd0);
    check1("rst_sready", s_if.tready, 1'b1);
    tick();

    // 2: full packet. Accepts at c=0..3, first word at c=2, last word at c=5,
    // trailer (seq 0, 4 events) at c=6, back to IDLE at c=7.
    m_if.tready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      logic [11:0] amp;
      amp = 12'(12'h101 + c);
      s_if.tvalid = (c < 4);
      s_if.tdata  = {20'hFFFFF, amp};
      @(negedge clk);
      if (c < 4) begin
        check1("t2_sready", s_if.tready, 1'b1);
        exp_q.push_back({tb_ts, amp});
      end
      if (c < 2) begin
        check1("t2_latency", m_if.tvalid, 1'b0);
      end else if (c < 6) begin
        check1("t2_word_valid", m_if.tvalid, 1'b1);
        check("t2_word_data", m_if.tdata, exp_q.pop_front());
        check1("t2_word_last", m_if.tlast, 1'b0);
      end else if (c == 6) begin
        check1("t2_trl_valid", m_if.tvalid, 1'b1);
        check("t2_trl_data", m_if.tdata, 32'hA500_0004);
        check1("t2_trl_last", m_if.tlast, 1'b1);
      end else begin
        check1("t2_idle_valid", m_if.tvalid, 1'b0);
        check("t2_pkt_count", packet_count, 32'd1);
      end
      tick();
    end
    s_if.tvalid = 1'b0;

    // 3: timeout. Pops at c=2,3; the idle timer is 0..15 over c=4..19 and the
    // state changes at the edge 16 cycles after the second pop: trailer at c=20.
    do_reset();
    m_if.tready = 1'b1;
    for (int c = 0; c < 21; c++) begin
      logic [11:0] amp;
      amp = 12'(12'h301 + c);
      s_if.tvalid = (c < 2);
      s_if.tdata  = {20'h12345, amp};
      @(negedge clk);
      if (c < 2) exp_q.push_back({tb_ts, amp});
      if (c < 2) begin
        check1("t3_latency", m_if.tvalid, 1'b0);
      end else if (c < 4) begin
        check1("t3_word_valid", m_if.tvalid, 1'b1);
        check("t3_word_data", m_if.tdata, exp_q.pop_front());
      end else if (c < 20) begin
        check1("t3_idle_no_valid", m_if.tvalid, 1'b0);
      end else begin
        check1("t3_trl_valid", m_if.tvalid, 1'b1);
        check("t3_trl_data", m_if.tdata, 32'hA500_0002);
        check1("t3_trl_last", m_if.tlast, 1'b1);
      end
      tick();
    end
    s_if.tvalid = 1'b0;
    @(negedge clk);
    check("t3_pkt_count", packet_count, 32'd1);
    tick();
    push_event("t3b_push", 12'h3FF);
    expect_beat("t3b_word", exp_q.pop_front(), 1'b0, 8);
    expect_beat("t3b_trl", 32'hA501_0001, 1'b1, 40);
    @(negedge clk);
    check("t3b_pkt_count", packet_count, 32'd2);
    tick();

    // 4: backpressure. 20 offers, only 16 fit; then drain 4 packets in order.
    do_reset();
    m_if.tready = 1'b0;
    accepted = 0;
    for (int c = 0; c < 20; c++) begin
      logic [11:0] amp;
      amp = 12'(12'h200 + accepted);
      s_if.tvalid = 1'b1;
      s_if.tdata  = {20'h0, amp};
      @(negedge clk);
      check1("t4_sready", s_if.tready, (c < 16));
      if (s_if.tready) begin
        exp_q.push_back({tb_ts, amp});
        accepted++;
      end
      tick();
    end
    s_if.tvalid = 1'b0;
    @(negedge clk);
    check("t4_accepted", 32'(accepted), 32'd16);
    check("t4_level_full", 32'(fifo_level), 32'd16);
    tick();
    m_if.tready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      for (int w = 0; w < 4; w++) expect_beat("t4_word", exp_q.pop_front(), 1'b0, 4);
      expect_beat("t4_trl", {8'hA5, 8'(p), 16'd4}, 1'b1, 4);
    end
    @(negedge clk);
    check("t4_level_empty", 32'(fifo_level), 32'd0);
    check("t4_pkt_count", packet_count, 32'd4);
    tick();

    // 5: stall stability with m_tready toggling every cycle (trailer seq 4).
    m_if.tready = 1'b0;
    for (int k = 0; k < 4; k++) push_event("t5_push", 12'(12'h500 + k));
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    xfers      = 0;
    stalls     = 0;
    for (int c = 0; c < 24; c++) begin
      m_if.tready = (c % 2 == 1);
      @(negedge clk);
      if (prev_stall) begin
        stalls++;
        check1("t5_hold_valid", m_if.tvalid, 1'b1);
        check("t5_hold_data", m_if.tdata, prev_data);
        check1("t5_hold_last", m_if.tlast, prev_last);
      end
      if (m_if.tvalid && m_if.tready) begin
        if (xfers < 4) begin
          check("t5_word_data", m_if.tdata, exp_q.pop_front());
          check1("t5_word_last", m_if.tlast, 1'b0);
        end else begin
          check("t5_trl_data", m_if.tdata, 32'hA504_0004);
          check1("t5_trl_last", m_if.tlast, 1'b1);
        end
        xfers++;
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_data  = m_if.tdata;
      prev_last  = m_if.tlast;
      tick();
    end
    check("t5_xfers", 32'(xfers), 32'd5);
    check1("t5_stalls_seen", (stalls > 0), 1'b1);
    check("t5_pkt_count", packet_count, 32'd5);

    // 6: reset with three events queued in STREAM; no trailer for that packet.
    m_if.tready = 1'b0;
    for (int k = 0; k < 3; k++) push_event("t6_push", 12'(12'h600 + k));
    exp_q.delete();
    tick();
    @(negedge clk);
    check1("t6_pre_valid", m_if.tvalid, 1'b1);
    check("t6_pre_level", 32'(fifo_level), 32'd3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check1("t6_post_valid", m_if.tvalid, 1'b0);
    check("t6_post_level", 32'(fifo_level), 32'd0);
    check("t6_post_pkt_count", packet_count, 32'd0);
    tick();
    m_if.tready = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      saw_valid = saw_valid | m_if.tvalid;
      tick();
    end
    check1("t6_no_trailer", saw_valid, 1'b0);
    push_event("t6b_push", 12'h6AB);
    expect_beat("t6b_word", exp_q.pop_front(), 1'b0, 8);
    expect_beat("t6b_trl", 32'hA500_0001, 1'b1, 40);
    @(negedge clk);
    check("t6b_pkt_count", packet_count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
